mcu_spi_cmd_rx: RTL and testbench
=================================

// Module: mcu_spi_cmd_rx
// PURPOSE
//  - MCU-side front end of the PSRAM path. Deserialises MCU SPI frames (SCLK/CS/MOSI, slave, receive-only) in the clk (100 MHz) domain.
//  - Decodes opcode, 24-bit address and length, then hands one command to the PSRAM64 controller via valid/ready.
//  - Buffers write payload bytes in a FIFO that the controller drains. Drives the MCU_REQ/MCU_ACK status handshake.
// PARAMETERS
//  DEPTH     64    write-payload FIFO depth in bytes (power of 2, 4..1024)
//  AW        24    command address width
//  LW        16    command length width
// PORTS
//  clk            in   1    system clock, 100 MHz (PLL output)
//  resetn         in   1    synchronous active-low reset
//  spi_sclk       in   1    MCU SPI clock, async; mode 0; f_sclk <= f_clk/8
//  spi_cs         in   1    MCU chip select, async, active-low
//  spi_mosi       in   1    MCU data, async, MSB first
//  mcu_req        in   1    MCU status request, async level
//  mcu_ack        out  1    status acknowledge to MCU
//  cmd_valid      out  1    command available
//  cmd_ready      in   1    controller accepts command
//  cmd_write      out  1    1 = write (payload in FIFO), 0 = read
//  cmd_addr       out  AW   byte address
//  cmd_len        out  LW   byte count
//  ctl_busy       in   1    controller executing a command
//  wr_rdreq       in   1    pop one payload byte
//  wr_data        out  8    FIFO head byte (show-ahead)
//  wr_empty       out  1    FIFO empty
//  frame_err      out  1    1-cycle pulse: truncated or unknown frame
//  overflow       out  1    sticky: payload byte dropped, FIFO full
// BEHAVIOUR
//  - Reset values: all outputs 0 except wr_empty=1; FIFO flushed; FSM IDLE; synchronisers cleared.
//  - Synchronisation: 2-FF sync on sclk/cs/mosi/req. A 3rd sclk stage gives a rise detect; mosi is sampled on the sclk rise.
//  - Bits: shift MSB first; a byte completes on the 8th rise. The bit counter clears on every cs fall.
//  - Frame formats:
//    - write: 0x02, A[23:16], A[15:8], A[7:0], D0..Dn
//    - read:  0x03, A[23:16], A[15:8], A[7:0], L[15:8], L[7:0]
//  - FSM states: IDLE, OPC, ADDR, LEN, DATA, SKIP, ISSUE.
//    - IDLE -> OPC on synced cs fall, but only if not ISSUE and ctl_busy=0. Otherwise the frame is ignored (stay IDLE, no error).
//    - OPC: 0x02/0x03 -> ADDR; any other value -> SKIP with a frame_err pulse.
//    - ADDR: after 3 bytes -> DATA (write) or LEN (read).
//    - LEN: after 2 bytes, extra bytes are discarded. On cs rise -> ISSUE.
//    - DATA: each byte is pushed to the FIFO and counted into cmd_len. On cs rise -> ISSUE.
//    - SKIP: on cs rise -> IDLE.
//    - cs rise in OPC/ADDR, or in LEN with <2 bytes: frame_err pulse, flush FIFO, -> IDLE, no command.
//    - ISSUE: cmd_valid=1 with fields stable until cmd_valid&cmd_ready, then -> IDLE the same cycle. Fields hold their last value afterwards.
//  - Write with 0 payload bytes issues cmd_len=0. A partial trailing byte (<8 bits) is discarded.
//  - FIFO full on a push: byte dropped, not counted, overflow=1. overflow clears on the next accepted cs fall.
//  - Simultaneous FIFO push and pop when full: the pop takes effect first, so the push succeeds.
//  - cmd_len saturates at 2^LW-1 (DEPTH always less than that).
//  - mcu_ack = req_sync & (state==IDLE) & ~ctl_busy, registered (1 clk after the condition).
//    - Deasserts 1 clk after req_sync falls. 4-phase: MCU drops req after seeing ack.
//  - Latency: cs rise sync edge -> cmd_valid = 1 clk. Last sclk rise -> byte push = 3 clk.
// STRUCTURE
//  - Package mcu_spi_pkg: OPC_WRITE=8'h02, OPC_READ=8'h03, state enum, header byte counts.
//  - Sub-module spi_byte_fifo: synchronous single-clock FIFO (DEPTH, show-ahead, flush, full/empty).
//  - Top file holds the synchronisers, shifter, FSM and handshake.
// TESTING
//  - Write 02 00 10 20 AA BB CC -> one cmd: write=1, addr=0x001020, len=3; pops yield AA, BB, CC, then wr_empty=1.
//  - Read 03 7F FF FF 00 40 -> cmd write=0, addr=0x7FFFFF, len=0x0040; FIFO stays empty.
//  - Opcode 0x55 + 4 bytes -> frame_err pulse, no cmd_valid; next valid frame decodes normally.
//  - cs rise after 02 12 34 -> frame_err, FIFO flushed, no cmd. Same with 03 + addr + 1 len byte.
//  - Write of DEPTH+5 bytes, no pops -> len=DEPTH, overflow=1. Overflow clears at the next frame's cs fall.
//  - cmd_ready low for 20 clk -> fields stable, second frame ignored; mcu_req held -> ack only after acceptance and ctl_busy=0.
//  - resetn low mid-DATA -> outputs at reset values, FIFO empty; a clean frame after release decodes correctly.

Source files
------------

// File: rtl/mcu_spi_pkg.sv
// Shared constants and FSM state type for the MCU SPI command receiver.
package mcu_spi_pkg;

    localparam logic [7:0] OPC_WRITE = 8'h02;
    localparam logic [7:0] OPC_READ  = 8'h03;

    localparam int unsigned ADDR_BYTES = 3;
    localparam int unsigned LEN_BYTES  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StOpc,
        StAddr,
        StLen,
        StData,
        StSkip,
        StIssue
    } rx_state_e;

endpackage

// File: rtl/spi_byte_fifo.sv
// Single-clock show-ahead byte FIFO with flush.
// A push into a full FIFO succeeds when a pop lands in the same cycle.
module spi_byte_fifo #(
    parameter int unsigned DEPTH = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [PW:0] wr_ptr_q, rd_ptr_q;
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + {{PW{1'b0}}, do_push};
            rd_ptr_q <= rd_ptr_q + {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/mcu_spi_cmd_rx.sv
// MCU SPI slave front end: synchronises SCLK/CS/MOSI, decodes read/write frames into one
// command for the PSRAM controller, buffers write payload, and answers the MCU_REQ handshake.
module mcu_spi_cmd_rx
    import mcu_spi_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 24,
    parameter int unsigned LW    = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          spi_sclk,
    input  logic          spi_cs,
    input  logic          spi_mosi,
    input  logic          mcu_req,
    output logic          mcu_ack,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic          cmd_write,
    output logic [AW-1:0] cmd_addr,
    output logic [LW-1:0] cmd_len,
    input  logic          ctl_busy,
    input  logic          wr_rdreq,
    output logic [7:0]    wr_data,
    output logic          wr_empty,
    output logic          frame_err,
    output logic          overflow
);

    logic [2:0] sclk_q, cs_q;
    logic [1:0] mosi_q, req_q;
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;

    rx_state_e     state_q, state_d;
    logic [1:0]    hdr_cnt_q, hdr_cnt_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          ack_q;

    logic       sclk_rise, cs_fall, cs_rise, cs_active, byte_done;
    logic [7:0] byte_val;
    logic       fifo_push, fifo_flush, fifo_full;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_active = ~cs_q[1];
    assign byte_val  = {shift_q, mosi_q[1]};
    assign byte_done = sclk_rise & cs_active & (bit_cnt_q == 3'd7);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sclk_q    <= '0;
            cs_q      <= '0;
            mosi_q    <= '0;
            req_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            cs_q   <= {cs_q[1:0], spi_cs};
            mosi_q <= {mosi_q[0], spi_mosi};
            req_q  <= {req_q[0], mcu_req};
            if (cs_fall) begin
                bit_cnt_q <= '0;
            end else if (sclk_rise && cs_active) begin
                shift_q   <= byte_val[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        err_d      = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            StIdle: begin
                if (cs_fall && !ctl_busy) begin
                    state_d   = StOpc;
                    hdr_cnt_d = '0;
                    len_d     = '0;
                    ovf_d     = 1'b0;
                end
            end
            StOpc: begin
                if (cs_rise) begin
                    err_d      = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = StIdle;
                end else if (byte_done) begin
                    if (byte_val == OPC_WRITE || byte_val == OPC_READ) begin
                        write_d = (byte_val == OPC_WRITE);
                        state_d = StAddr;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StSkip;
                    end
                end
            end
            StAddr: begin
                if (cs_rise) begin
                    err_d      = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = StIdle;
                end else if (byte_done) begin
                    addr_d    = {addr_q[AW-9:0], byte_val};
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'(ADDR_BYTES - 1)) begin
                        hdr_cnt_d = '0;
                        state_d   = write_q ? StData : StLen;
                    end
                end
            end
            StLen: begin
                if (cs_rise) begin
                    if (hdr_cnt_q == 2'(LEN_BYTES)) begin
                        state_d = StIssue;
                    end else begin
                        err_d      = 1'b1;
                        fifo_flush = 1'b1;
                        state_d    = StIdle;
                    end
                end else if (byte_done && hdr_cnt_q != 2'(LEN_BYTES)) begin
                    len_d     = {len_q[LW-9:0], byte_val};
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                end
            end
            StData: begin
                if (byte_done) begin
                    fifo_push = 1'b1;
                    // A same-cycle pop frees the slot, so only a full FIFO without a pop drops.
                    if (fifo_full && !wr_rdreq) begin
                        ovf_d = 1'b1;
                    end else if (len_q != '1) begin
                        len_d = len_q + LW'(1);
                    end
                end
                if (cs_rise) begin
                    state_d = StIssue;
                end
            end
            StSkip: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                if (cmd_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            hdr_cnt_q <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            ack_q     <= req_q[1] & (state_q == StIdle) & ~ctl_busy;
        end
    end

    spi_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (byte_val),
        .pop_i   (wr_rdreq),
        .rdata_o (wr_data),
        .empty_o (wr_empty),
        .full_o  (fifo_full)
    );

    assign cmd_valid = (state_q == StIssue);
    assign cmd_write = write_q;
    assign cmd_addr  = addr_q;
    assign cmd_len   = len_q;
    assign frame_err = err_q;
    assign overflow  = ovf_q;
    assign mcu_ack   = ack_q;

endmodule

// File: tb/tb_mcu_spi_cmd_rx.sv
// Scoreboard bench for mcu_spi_cmd_rx: expected commands and payload bytes are queued as
// frames are sent and compared when the DUT hands them over.
module tb_mcu_spi_cmd_rx;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 24;
    localparam int unsigned LW    = 16;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } cmd_t;

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          resetn, spi_sclk, spi_cs, spi_mosi, mcu_req, mcu_ack;
    logic          cmd_valid, cmd_ready, cmd_write, ctl_busy, wr_rdreq, wr_empty;
    logic          frame_err, overflow;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [7:0]    wr_data;

    cmd_t       exp_cmd_q[$];
    logic [7:0] exp_byte_q[$];
    cmd_t       mon_e;
    int         checks = 0;
    int         failures = 0;
    int         n_cmd = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    mcu_spi_cmd_rx #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .LW    (LW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .spi_sclk  (spi_sclk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .mcu_req   (mcu_req),
        .mcu_ack   (mcu_ack),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ctl_busy  (ctl_busy),
        .wr_rdreq  (wr_rdreq),
        .wr_data   (wr_data),
        .wr_empty  (wr_empty),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Command monitor: every handshake pops one expected command.
    always @(negedge clk) begin
        if (resetn && frame_err) n_err++;
        if (resetn && cmd_valid && cmd_ready) begin
            n_cmd++;
            if (exp_cmd_q.size() == 0) begin
                check("cmd_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_cmd_q.pop_front();
                check("cmd_write", 32'(cmd_write), 32'(mon_e.wr));
                check("cmd_addr", 32'(cmd_addr), 32'(mon_e.addr));
                check("cmd_len", 32'(cmd_len), 32'(mon_e.len));
            end
        end
    end

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            #50 spi_sclk = 1'b1;
            #50 spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi_cs = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #100 spi_cs = 1'b1;
        #300;
    endtask

    task automatic send_frame(input byte_q_t bytes);
        cs_begin();
        foreach (bytes[i]) spi_byte(bytes[i]);
        cs_end();
    endtask

    task automatic wait_cmds(input int target);
        for (int i = 0; i < 500 && n_cmd < target; i++) @(negedge clk);
        check("cmd_count", 32'(n_cmd), 32'(target));
    endtask

    task automatic drain();
        logic [7:0] e;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (wr_empty) break;
            if (exp_byte_q.size() == 0) begin
                check("wr_extra_byte", 32'(wr_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_byte_q.pop_front();
                check("wr_data", 32'(wr_data), 32'(e));
            end
            wr_rdreq = 1'b1;
            @(posedge clk);
            #1 wr_rdreq = 1'b0;
        end
        check("wr_empty_after_drain", 32'(wr_empty), 32'd1);
        check("bytes_left", 32'(exp_byte_q.size()), 32'd0);
    endtask

    initial begin
        byte_q_t frame;
        int      err0;

        resetn = 1'b0; spi_sclk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        mcu_req = 1'b0; cmd_ready = 1'b1; ctl_busy = 1'b0; wr_rdreq = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_ack", 32'(mcu_ack), 32'd0);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_write", 32'(cmd_write), 32'd0);
        check("rst_addr", 32'(cmd_addr), 32'd0);
        check("rst_len", 32'(cmd_len), 32'd0);
        check("rst_empty", 32'(wr_empty), 32'd1);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk) #1 resetn = 1'b1;
        repeat (5) @(posedge clk);

        // Basic write with three payload bytes.
        exp_cmd_q.push_back('{wr: 1'b1, addr: 24'h001020, len: 16'd3});
        exp_byte_q.push_back(8'hAA); exp_byte_q.push_back(8'hBB); exp_byte_q.push_back(8'hCC);
        frame = '{8'h02, 8'h00, 8'h10, 8'h20, 8'hAA, 8'hBB, 8'hCC};
        send_frame(frame);
        wait_cmds(1);
        drain();

        // Read command.
        exp_cmd_q.push_back('{wr: 1'b0, addr: 24'h7FFFFF, len: 16'h0040});
        frame = '{8'h03, 8'h7F, 8'hFF, 8'hFF, 8'h00, 8'h40};
        send_frame(frame);
        wait_cmds(2);
        check("read_fifo_empty", 32'(wr_empty), 32'd1);

        // Unknown opcode, then a valid frame.
        frame = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(frame);
        repeat (20) @(negedge clk);
        check("badopc_no_cmd", 32'(n_cmd), 32'd2);
        check("badopc_err", 32'(n_err), 32'd1);
        exp_cmd_q.push_back('{wr: 1'b0, addr: 24'h123456, len: 16'h0002});
        frame = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h02};
        send_frame(frame);
        wait_cmds(3);

        // Truncated headers.
        frame = '{8'h02, 8'h12, 8'h34};
        send_frame(frame);
        repeat (20) @(negedge clk);
        check("trunc_addr_err", 32'(n_err), 32'd2);
        check("trunc_addr_empty", 32'(wr_empty), 32'd1);
        frame = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(frame);
        repeat (20) @(negedge clk);
        check("trunc_len_err", 32'(n_err), 32'd3);
        check("trunc_no_cmd", 32'(n_cmd), 32'd3);

        // Overflow: DEPTH+5 payload bytes with no pops.
        exp_cmd_q.push_back('{wr: 1'b1, addr: 24'h000000, len: 16'(DEPTH)});
        frame = '{8'h02, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < int'(DEPTH) + 5; i++) begin
            frame.push_back(8'(i));
            if (i < int'(DEPTH)) exp_byte_q.push_back(8'(i));
        end
        send_frame(frame);
        wait_cmds(4);
        check("ovf_set", 32'(overflow), 32'd1);
        drain();
        check("ovf_sticky", 32'(overflow), 32'd1);
        exp_cmd_q.push_back('{wr: 1'b0, addr: 24'h000005, len: 16'h0001});
        cs_begin();
        repeat (5) @(negedge clk);
        check("ovf_cleared", 32'(overflow), 32'd0);
        spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h05);
        spi_byte(8'h00); spi_byte(8'h01);
        cs_end();
        wait_cmds(5);

        // Stalled cmd_ready: fields stable, second frame ignored, ack gated.
        cmd_ready = 1'b0;
        exp_cmd_q.push_back('{wr: 1'b0, addr: 24'h000100, len: 16'h0007});
        frame = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h07};
        send_frame(frame);
        for (int i = 0; i < 200 && !cmd_valid; i++) @(negedge clk);
        check("stall_valid", 32'(cmd_valid), 32'd1);
        mcu_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_addr", 32'(cmd_addr), 32'h000100);
            check("stall_len", 32'(cmd_len), 32'h0007);
        end
        err0 = n_err;
        frame = '{8'h02, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22};
        send_frame(frame);
        repeat (5) @(negedge clk);
        check("ignored_empty", 32'(wr_empty), 32'd1);
        check("ignored_no_err", 32'(n_err), 32'(err0));
        check("ignored_addr", 32'(cmd_addr), 32'h000100);
        check("ack_while_issue", 32'(mcu_ack), 32'd0);
        @(posedge clk) #1;
        ctl_busy = 1'b1;
        cmd_ready = 1'b1;
        wait_cmds(6);
        repeat (5) @(negedge clk);
        check("ack_while_busy", 32'(mcu_ack), 32'd0);
        ctl_busy = 1'b0;
        repeat (4) @(negedge clk);
        check("ack_set", 32'(mcu_ack), 32'd1);
        mcu_req = 1'b0;
        repeat (4) @(negedge clk);
        check("ack_clear", 32'(mcu_ack), 32'd0);
        repeat (20) @(negedge clk);
        check("ignored_no_cmd", 32'(n_cmd), 32'd6);

        // Reset in the middle of a write payload.
        err0 = n_err;
        cs_begin();
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00);
        spi_byte(8'hAA); spi_byte(8'hBB);
        repeat (5) @(negedge clk);
        check("pre_rst_fifo", 32'(wr_empty), 32'd0);
        @(posedge clk) #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_empty", 32'(wr_empty), 32'd1);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_ack", 32'(mcu_ack), 32'd0);
        check("mid_rst_err", 32'(frame_err), 32'd0);
        @(posedge clk) #1 resetn = 1'b1;
        cs_end();
        repeat (10) @(negedge clk);
        check("post_rst_no_err", 32'(n_err), 32'(err0));
        check("post_rst_no_cmd", 32'(n_cmd), 32'd6);

        // Clean frame after reset.
        exp_cmd_q.push_back('{wr: 1'b1, addr: 24'hABCDEF, len: 16'd1});
        exp_byte_q.push_back(8'h5A);
        frame = '{8'h02, 8'hAB, 8'hCD, 8'hEF, 8'h5A};
        send_frame(frame);
        wait_cmds(7);
        drain();
        check("cmds_left", 32'(exp_cmd_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
